vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vga_pkg.sv | 19 +
 rtl/pix_fifo.sv | 59 +++++
 rtl/vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants for the 1024x768 VGA video path.
//   Timing totals and active sizes used by the timing generator, the number
//   of 32-bit frame-buffer words per frame (8 bpp, 4 px/word), and the state
//   enum of the VRAM arbiter FSM.
package vga_pkg;

  localparam int H_TOTAL     = 1344;
  localparam int V_TOTAL     = 806;
  localparam int H_ACTIVE    = 1024;
  localparam int V_ACTIVE    = 768;
  localparam int FRAME_WORDS = (H_ACTIVE * V_ACTIVE) / 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_WAIT = 2'd1,
    CPU_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo -- synchronous pixel-word prefetch FIFO with flush.
//   clk, clr_n   : clock, async active-low reset
//   flush_i      : empty the FIFO; wins over push/pop in the same cycle
//   push_i/wdata_i : write one word (ignored when full and not popping)
//   pop_i        : consume head word; no effect when empty
//   rdata_o      : head word, 0 when empty
//   empty_o, count_o : status
// DEPTH must be a power of 2 (pointers wrap naturally).
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- single-port VRAM arbiter between the VGA prefetch path and
// a CPU port. Every access is two cycles: issue in IDLE, complete in a WAIT
// state. The VGA path keeps pix_fifo topped up from fb_base onward, reloaded
// at each frame restart (vc==VLINES-1, hc==0).
//   Timing in : hc, vc, fb_base
//   Pixel out : pix_pop -> pix_data, pix_empty, underrun, underrun_cnt
//   CPU port  : cpu_req/we/addr/wdata -> cpu_ack, cpu_rdata (2 cycles after grant)
//   Memory    : mem_en/we/addr/wdata, mem_rdata one cycle after mem_en
// Build option: define VRAM_ARB_STATS_EN to get a saturating 16-bit underrun
// counter on underrun_cnt; otherwise underrun_cnt is tied to 0.
module vram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOW_WM      = 2,
  parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS,
  parameter int VLINES      = vga_pkg::V_TOTAL
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [11:0]       hc,
  input  logic [11:0]       vc,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              pix_pop,
  output logic [31:0]       pix_data,
  output logic              pix_empty,
  output logic              underrun,
  output logic [15:0]       underrun_cnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  import vga_pkg::*;

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OW  = CW + 1;
  localparam int FCW = $clog2(FRAME_WORDS + 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] faddr_q;
  logic [FCW-1:0]    fcnt_q;
  logic              run_q, cpu_ack_q, cpu_we_q, underrun_q;
  logic [31:0]       cpu_rdata_q;
  logic [CW-1:0]     fifo_cnt;
  logic [OW-1:0]     eff_occ;
  logic              restart, vga_elig, cpu_go, grant_vga, grant_cpu, push;

  assign restart  = (vc == 12'(VLINES - 1)) && (hc == 12'd0);
  // A read in flight already owns a FIFO slot.
  assign eff_occ  = OW'(fifo_cnt) + OW'(state_q == VGA_WAIT);
  // No VGA issue on the restart cycle itself: the fetch address is being reloaded.
  assign vga_elig = !restart && (eff_occ < OW'(FIFO_DEPTH)) && (fcnt_q < FCW'(FRAME_WORDS));
  // cpu_req is still high during the ack cycle; don't re-grant the finished request.
  // run_q keeps the bus quiet through reset and the first cycle after it.
  assign cpu_go   = cpu_req && run_q && !cpu_ack_q;
  assign push     = (state_q == VGA_WAIT) && !restart;

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .clr_n   (clr_n),
    .flush_i (restart),
    .push_i  (push),
    .wdata_i (mem_rdata),
    .pop_i   (pix_pop),
    .rdata_o (pix_data),
    .empty_o (pix_empty),
    .count_o (fifo_cnt)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: arbitration and next state
  always_comb begin
    state_d   = IDLE;
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == IDLE) begin
      if (vga_elig && (eff_occ < OW'(LOW_WM))) grant_vga = 1'b1;
      else if (cpu_go)                         grant_cpu = 1'b1;
      else if (vga_elig)                       grant_vga = 1'b1;
      if (grant_vga)      state_d = VGA_WAIT;
      else if (grant_cpu) state_d = CPU_WAIT;
    end
  end

  // FSM: memory-bus outputs (issue cycle only)
  always_comb begin
    mem_en    = grant_vga | grant_cpu;
    mem_we    = grant_cpu & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_vga) mem_addr = faddr_q;
    if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      run_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      underrun_q  <= 1'b0;
      faddr_q     <= '0;
      fcnt_q      <= FCW'(FRAME_WORDS);
    end else begin
      run_q     <= 1'b1;
      cpu_ack_q <= (state_q == CPU_WAIT);
      if (grant_cpu) cpu_we_q <= cpu_we;
      if ((state_q == CPU_WAIT) && !cpu_we_q) cpu_rdata_q <= mem_rdata;
      if (pix_pop && pix_empty) underrun_q <= 1'b1;
      if (restart) begin
        faddr_q <= fb_base;
        fcnt_q  <= '0;
      end else if (push) begin
        faddr_q <= faddr_q + 1'b1;
        fcnt_q  <= fcnt_q + 1'b1;
      end
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign underrun  = underrun_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] ur_cnt_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                          ur_cnt_q <= '0;
    else if (pix_pop && pix_empty && ur_cnt_q != 16'hFFFF) ur_cnt_q <= ur_cnt_q + 16'd1;
  end
  assign underrun_cnt = ur_cnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed bench for vram_arbiter with a cycle-level
// behavioural model (FIFO as a queue, memory as an associative array)
// checked every cycle, plus literal expectations for the key scenarios.
module tb_vram_arbiter;
  localparam int AW = 18;
  localparam int FW = 196608;
`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic [11:0]   hc, vc;
  logic [AW-1:0] fb_base;
  logic          pix_pop;
  logic [31:0]   pix_data;
  logic          pix_empty, underrun;
  logic [15:0]   underrun_cnt;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_ack;
  logic [31:0]   cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(4), .LOW_WM(2), .FRAME_WORDS(FW), .VLINES(806)) dut (
    .clk(clk), .clr_n(clr_n), .hc(hc), .vc(vc), .fb_base(fb_base),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_empty(pix_empty),
    .underrun(underrun), .underrun_cnt(underrun_cnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Video memory: unwritten words read back as a pattern of their address.
  logic [31:0] vmem [logic [AW-1:0]];
  function automatic logic [31:0] rd(input logic [AW-1:0] a);
    if (vmem.exists(a)) return vmem[a];
    return 32'hC0DE_0000 ^ {14'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vmem[mem_addr] = mem_wdata;
      else        mem_rdata <= rd(mem_addr);
    end
  end

  // Behavioural model, evaluated mid-cycle when inputs and outputs are settled.
  logic [31:0]   q[$];
  int            m_busy;          // 0 idle, 1 VGA read outstanding, 2 CPU access outstanding
  logic [AW-1:0] m_addr;
  int            m_cnt;
  logic          m_ack, m_pend_we, m_ur;
  logic [31:0]   m_rdata, m_pend;
  int            m_urc;
  logic [AW-1:0] vga_log[$];

  always @(negedge clk) begin : model
    logic rs, elig, gv, gc;
    int   eff;
    if (!clr_n) begin
      chk("rst_pix_empty", pix_empty, 1);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_underrun_cnt", underrun_cnt, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      q.delete();
      m_busy = 0; m_addr = '0; m_cnt = FW; m_ack = 0; m_pend_we = 0;
      m_ur = 0; m_rdata = '0; m_pend = '0; m_urc = 0;
    end else begin
      rs   = (vc == 12'd805) && (hc == 12'd0);
      eff  = q.size() + ((m_busy == 1) ? 1 : 0);
      elig = !rs && (eff < 4) && (m_cnt < FW);
      gv = 0; gc = 0;
      if (m_busy == 0) begin
        if (elig && eff < 2)          gv = 1;
        else if (cpu_req && !m_ack)   gc = 1;
        else if (elig)                gv = 1;
      end
      chk("pix_empty", pix_empty, (q.size() == 0));
      chk("pix_data", pix_data, (q.size() == 0) ? 32'h0 : q[0]);
      chk("underrun", underrun, m_ur);
      chk("underrun_cnt", underrun_cnt, STATS ? m_urc : 0);
      chk("cpu_ack", cpu_ack, m_ack);
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("mem_en", mem_en, gv | gc);
      chk("mem_we", mem_we, gc & cpu_we);
      if (gv) begin
        chk("vga_addr", mem_addr, m_addr);
        vga_log.push_back(mem_addr);
      end
      if (gc) begin
        chk("cpu_addr", mem_addr, cpu_addr);
        chk("cpu_wdata", mem_wdata, cpu_wdata);
      end
      // advance to the next cycle
      m_ack = (m_busy == 2);
      if (m_busy == 2 && !m_pend_we) m_rdata = m_pend;
      if (pix_pop) begin
        if (q.size() == 0) begin
          m_ur = 1;
          if (m_urc < 65535) m_urc++;
        end else void'(q.pop_front());
      end
      if (m_busy == 1 && !rs) begin
        q.push_back(m_pend);
        m_addr++;
        m_cnt++;
      end
      if (rs) begin
        q.delete();
        m_addr = fb_base;
        m_cnt  = 0;
      end
      m_busy = gv ? 1 : (gc ? 2 : 0);
      if (gv) m_pend = rd(m_addr);
      if (gc) begin
        m_pend    = rd(cpu_addr);
        m_pend_we = cpu_we;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    vc = 12'd805; hc = 12'd0;
    tick(1);
    vc = 12'd0; hc = 12'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nack;
    hc = 12'd1; vc = 12'd0; fb_base = 18'h100; pix_pop = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vmem[18'h2000] = 32'hDEADBEEF;
    #1 clr_n = 0;
    tick(3);
    chk("lit_rst_empty", pix_empty, 1);
    chk("lit_rst_mem_en", mem_en, 0);
    clr_n = 1;
    tick(4);
    chk("lit_no_fetch_before_frame", vga_log.size(), 0);

    // frame restart with no pops: four fetches from fb_base, then full
    restart();
    tick(12);
    chk("lit_fill_count", vga_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("lit_fill_addr", vga_log[i], 32'h100 + i);
    chk("lit_fill_not_empty", pix_empty, 0);
    chk("lit_fill_head", pix_data, 32'hC0DE0100);

    // CPU read while FIFO full
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h2000; #2;
    chk("lit_cpu_rd_en", mem_en, 1);
    chk("lit_cpu_rd_we", mem_we, 0);
    chk("lit_cpu_rd_addr", mem_addr, 32'h2000);
    k = 0;
    do begin tick(1); k++; end while (!cpu_ack && k < 8);
    chk("lit_cpu_ack_latency", k, 2);
    chk("lit_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;
    tick(1);
    chk("lit_cpu_ack_pulse", cpu_ack, 0);

    // pop every 4 cycles against a continuous CPU write stream
    cpu_we = 1; cpu_addr = 18'h4000; cpu_wdata = 32'h1111_0000; cpu_req = 1; nack = 0;
    for (int c = 0; c < 1024; c++) begin
      pix_pop = (c % 4 == 0);
      tick(1);
      if (cpu_ack) begin
        nack++;
        cpu_addr++;
        cpu_wdata++;
      end
    end
    pix_pop = 0; cpu_req = 0;
    tick(1);
    chk("lit_stream_no_underrun", underrun, 0);
    chk("lit_stream_acks", (nack >= 64), 1);

    // underrun: pops right after a restart find the FIFO empty
    tick(4);
    restart();
    pix_pop = 1; #2;
    chk("lit_ur_empty", pix_empty, 1);
    chk("lit_ur_data", pix_data, 0);
    tick(1);
    tick(1);
    pix_pop = 0;
    chk("lit_ur_flag", underrun, 1);
    tick(4);
    restart();
    pix_pop = 1;
    tick(1);
    pix_pop = 0;
    tick(1);
    chk("lit_ur_count", underrun_cnt, STATS ? 3 : 0);

    // restart while a VGA read is outstanding
    tick(12);
    fb_base = 18'h300;
    pix_pop = 1;
    tick(1);
    pix_pop = 0; #2;
    chk("lit_refetch_issue", mem_en, 1);
    tick(1);
    vc = 12'd805; hc = 12'd0; #2;
    chk("lit_wait_no_en", mem_en, 0);
    tick(1);
    vc = 12'd0; hc = 12'd1; #2;
    chk("lit_restart_empty", pix_empty, 1);
    chk("lit_new_base_en", mem_en, 1);
    chk("lit_new_base_addr", mem_addr, 32'h300);

    // reset during CPU_WAIT
    tick(12);
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h5000; cpu_wdata = 32'hCAFE_F00D; #2;
    chk("lit_abort_issue", mem_en, 1);
    tick(1);
    clr_n = 0; cpu_req = 0; #2;
    chk("lit_abort_no_ack", cpu_ack, 0);
    tick(2);
    clr_n = 1;
    tick(1);
    chk("lit_post_ack", cpu_ack, 0);
    chk("lit_post_empty", pix_empty, 1);
    chk("lit_post_data", pix_data, 0);
    chk("lit_post_underrun", underrun, 0);
    chk("lit_post_ur_cnt", underrun_cnt, 0);
    chk("lit_post_rdata", cpu_rdata, 0);
    chk("lit_post_mem_addr", mem_addr, 0);
    tick(3);
    chk("lit_post_no_fetch", mem_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
